// File: rtl/tis_fetch_seq_pkg.sv
// Shared encodings for the TIS-100 fetch sequencer: jump-select codes and
// instruction field positions (instruction bit 0 is the MSB).
package tis_fetch_seq_pkg;

  typedef enum logic [1:0] {
    JSEL_INC = 2'b00,
    JSEL_ABS = 2'b01,
    JSEL_IMM = 2'b10,
    JSEL_REL = 2'b11
  } jsel_e;

  localparam int TYPE_W = 5;   // instr[0:4]
  localparam int TGT_LO = 10;  // target field is instr[10:INSTR_W-1]

endpackage

// File: rtl/tis_pc_next.sv
// Ungated next-PC selection: increment with wrap, absolute/immediate with
// range check, and saturating relative jump.
module tis_pc_next
  import tis_fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OFF_W  = 11
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic [1:0]        jmp_sel,
  input  logic [ADDR_W-1:0] jaddr,
  input  logic [ADDR_W-1:0] instr_imm,
  input  logic [OFF_W-1:0]  jro_off,
  output logic [ADDR_W-1:0] pc_next
);

  localparam int SW = ADDR_W + OFF_W + 1;

  logic [ADDR_W:0]        inc;
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   len_s;

  always_comb begin
    // one extra bit so pc=2^ADDR_W-1 still compares correctly against prog_len
    inc   = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
    sum   = $signed({{(SW-ADDR_W){1'b0}}, pc})
          + $signed({{(SW-OFF_W){jro_off[OFF_W-1]}}, jro_off});
    len_s = $signed({{(SW-ADDR_W){1'b0}}, prog_len});
    pc_next = '0;
    case (jsel_e'(jmp_sel))
      JSEL_INC: pc_next = (inc >= {1'b0, prog_len}) ? '0 : inc[ADDR_W-1:0];
      JSEL_ABS: pc_next = (jaddr >= prog_len) ? '0 : jaddr;
      JSEL_IMM: pc_next = (instr_imm >= prog_len) ? '0 : instr_imm;
      JSEL_REL: begin
        if (sum[SW-1])          pc_next = '0;
        else if (sum >= len_s)  pc_next = prog_len - {{(ADDR_W-1){1'b0}}, 1'b1};
        else                    pc_next = sum[ADDR_W-1:0];
      end
      default:  pc_next = '0;
    endcase
  end

endmodule

// File: rtl/tis_fetch_seq.sv
// Instruction-fetch sequencer for one TIS-100 node: PC register driving a
// 1-cycle synchronous instruction memory so rdata lines up with pc.
module tis_fetch_seq
  import tis_fetch_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 18,
  parameter int OFF_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  prog_len,
  input  logic               stall,
  input  logic [1:0]         jmp_sel,
  input  logic [ADDR_W-1:0]  jaddr,
  input  logic [OFF_W-1:0]   jro_off,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  output logic [4:0]         instr_type,
  output logic [ADDR_W-1:0]  instr_imm
);

  localparam int TGT_W = INSTR_W - TGT_LO;

  logic [ADDR_W-1:0] pc_core;
  logic [ADDR_W-1:0] pc_next;
  logic              unused_mid;

  // decode is forced to zero while warming up so stale/X memory data never
  // reaches the immediate jump path
  assign instr_type = instr_valid ? imem_rdata[INSTR_W-1 -: TYPE_W] : '0;
  assign instr_imm  = instr_valid ? ADDR_W'(imem_rdata[TGT_W-1:0]) : '0;
  assign unused_mid = ^imem_rdata[INSTR_W-1-TYPE_W:TGT_W];

  tis_pc_next #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_pc_next (
    .pc        (pc),
    .prog_len  (prog_len),
    .jmp_sel   (jmp_sel),
    .jaddr     (jaddr),
    .instr_imm (instr_imm),
    .jro_off   (jro_off),
    .pc_next   (pc_core)
  );

  // reset also zeroes the memory address so the reset edge latches word 0
  always_comb begin
    pc_next = '0;
    if (reset || !instr_valid || prog_len == '0) pc_next = '0;
    else if (stall)                              pc_next = pc;
    else                                         pc_next = pc_core;
  end

  assign imem_addr = pc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_next;
      instr_valid <= (prog_len != '0);
    end
  end

endmodule

// File: tb/tb_tis_fetch_seq.sv
// Directed bench for tis_fetch_seq with a behavioural synchronous memory.
module tb_tis_fetch_seq;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 18;
  localparam int OFF_W   = 11;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  prog_len;
  logic               stall;
  logic [1:0]         jmp_sel;
  logic [ADDR_W-1:0]  jaddr;
  logic [OFF_W-1:0]   jro_off;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  pc;
  logic               instr_valid;
  logic [4:0]         instr_type;
  logic [ADDR_W-1:0]  instr_imm;

  logic [INSTR_W-1:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tis_fetch_seq #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .reset(reset), .prog_len(prog_len), .stall(stall),
    .jmp_sel(jmp_sel), .jaddr(jaddr), .jro_off(jro_off),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .instr_valid(instr_valid), .instr_type(instr_type), .instr_imm(instr_imm)
  );

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // word = {type=addr[4:0], 5'b10101, target=addr+5}
  function automatic logic [INSTR_W-1:0] word_at(input logic [7:0] a);
    logic [7:0] t;
    t = a + 8'd5;
    return {a[4:0], 5'b10101, t};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; stall = 1'b0; jmp_sel = 2'b00; jaddr = '0; jro_off = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic goto_pc(input int len, input int tgt);
    prog_len = ADDR_W'(len);
    do_reset();
    repeat (tgt) tick();
    checks++;
    if (pc !== ADDR_W'(tgt)) begin failures++; $display("FAIL goto_pc pc=%0d exp=%0d", pc, tgt); end
  endtask

  task automatic test_reset;
    reset = 1'b1; prog_len = 8'd5; stall = 1'b0; jmp_sel = 2'b00; jaddr = '0; jro_off = '0;
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc pc=%0d exp=0", pc); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++;
    if (imem_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 8'd0) begin failures++; $display("FAIL warm_addr got=%0d exp=0", imem_addr); end
  endtask

  task automatic test_inc;
    for (int i = 0; i < 12; i++) begin
      int e;
      e = i % 5;
      tick();
      checks++;
      if (instr_valid !== 1'b1) begin failures++; $display("FAIL inc_valid[%0d] got=%b exp=1", i, instr_valid); end
      checks++;
      if (pc !== ADDR_W'(e)) begin failures++; $display("FAIL inc_pc[%0d] pc=%0d exp=%0d", i, pc, e); end
      checks++;
      if (imem_rdata !== word_at(8'(e))) begin failures++; $display("FAIL inc_rdata[%0d] got=%h exp=%h", i, imem_rdata, word_at(8'(e))); end
      checks++;
      if (instr_type !== 5'(e)) begin failures++; $display("FAIL inc_type[%0d] got=%0d exp=%0d", i, instr_type, e); end
    end
  endtask

  task automatic test_stall;
    goto_pc(8, 3);
    stall = 1'b1; jmp_sel = 2'b01; jaddr = 8'd1;
    #1;
    checks++;
    if (imem_addr !== 8'd3) begin failures++; $display("FAIL stall_addr0 got=%0d exp=3", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== 8'd3) begin failures++; $display("FAIL stall_pc[%0d] pc=%0d exp=3", i, pc); end
      checks++;
      if (imem_addr !== 8'd3) begin failures++; $display("FAIL stall_addr[%0d] got=%0d exp=3", i, imem_addr); end
      checks++;
      if (instr_type !== 5'd3) begin failures++; $display("FAIL stall_type[%0d] got=%0d exp=3", i, instr_type); end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 8'd1) begin failures++; $display("FAIL unstall_addr got=%0d exp=1", imem_addr); end
    tick();
    checks++;
    if (pc !== 8'd1) begin failures++; $display("FAIL unstall_pc pc=%0d exp=1", pc); end
    checks++;
    if (imem_rdata !== word_at(8'd1)) begin failures++; $display("FAIL unstall_rdata got=%h exp=%h", imem_rdata, word_at(8'd1)); end
  endtask

  task automatic test_rel;
    goto_pc(10, 4);
    jmp_sel = 2'b11; jro_off = OFF_W'(-7);
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL rel_neg pc=%0d exp=0", pc); end
    checks++;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL rel_valid got=%b exp=1", instr_valid); end
    checks++;
    if (imem_rdata !== word_at(8'd0)) begin failures++; $display("FAIL rel_rdata got=%h exp=%h", imem_rdata, word_at(8'd0)); end
    jmp_sel = 2'b01; jaddr = 8'd4;
    tick();
    checks++;
    if (pc !== 8'd4) begin failures++; $display("FAIL abs4a pc=%0d exp=4", pc); end
    jmp_sel = 2'b11; jro_off = OFF_W'(20);
    tick();
    checks++;
    if (pc !== 8'd9) begin failures++; $display("FAIL rel_sat_hi pc=%0d exp=9", pc); end
    jmp_sel = 2'b01; jaddr = 8'd4;
    tick();
    jmp_sel = 2'b11; jro_off = OFF_W'(2);
    tick();
    checks++;
    if (pc !== 8'd6) begin failures++; $display("FAIL rel_pos pc=%0d exp=6", pc); end
    checks++;
    if (imem_rdata !== word_at(8'd6)) begin failures++; $display("FAIL rel_pos_rdata got=%h exp=%h", imem_rdata, word_at(8'd6)); end
    jro_off = OFF_W'(-6);
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL rel_exact0 pc=%0d exp=0", pc); end
  endtask

  task automatic test_imm;
    goto_pc(6, 0);
    checks++;
    if (instr_imm !== 8'd5) begin failures++; $display("FAIL imm_field got=%0d exp=5", instr_imm); end
    jmp_sel = 2'b10;
    tick();
    checks++;
    if (pc !== 8'd5) begin failures++; $display("FAIL imm_taken pc=%0d exp=5", pc); end
    checks++;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL imm_nobubble got=%b exp=1", instr_valid); end
    checks++;
    if (instr_imm !== 8'd10) begin failures++; $display("FAIL imm_field5 got=%0d exp=10", instr_imm); end
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL imm_oob10 pc=%0d exp=0", pc); end
    jmp_sel = 2'b00;
    repeat (3) tick();
    checks++;
    if (instr_imm !== 8'h08) begin failures++; $display("FAIL imm_field3 got=%0d exp=8", instr_imm); end
    jmp_sel = 2'b10;
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL imm_oob8 pc=%0d exp=0", pc); end
    jmp_sel = 2'b00;
    tick();
    jmp_sel = 2'b10;
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL imm_eq_len pc=%0d exp=0", pc); end
  endtask

  task automatic test_zero_len;
    prog_len = 8'd0; reset = 1'b1; stall = 1'b0; jmp_sel = 2'b00;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL zlen_valid[%0d] got=%b exp=0", i, instr_valid); end
      checks++;
      if (pc !== 8'd0) begin failures++; $display("FAIL zlen_pc[%0d] pc=%0d exp=0", i, pc); end
    end
    prog_len = 8'd3;
    tick();
    checks++;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL zlen_up_valid got=%b exp=1", instr_valid); end
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL zlen_up_pc pc=%0d exp=0", pc); end
    tick();
    checks++;
    if (pc !== 8'd1) begin failures++; $display("FAIL zlen_run pc=%0d exp=1", pc); end
    prog_len = 8'd0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'd0) begin
      failures++; $display("FAIL zlen_drop valid=%b pc=%0d exp valid=0 pc=0", instr_valid, pc);
    end
  endtask

  task automatic test_shrink;
    goto_pc(10, 7);
    prog_len = 8'd4; jmp_sel = 2'b00;
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL shrink_inc pc=%0d exp=0", pc); end
    prog_len = 8'd10; jmp_sel = 2'b01; jaddr = 8'd7;
    tick();
    prog_len = 8'd4; jmp_sel = 2'b11; jro_off = '0;
    tick();
    checks++;
    if (pc !== 8'd3) begin failures++; $display("FAIL shrink_rel pc=%0d exp=3", pc); end
    jmp_sel = 2'b01; jaddr = 8'd4;
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL shrink_abs pc=%0d exp=0", pc); end
  endtask

  task automatic test_reset_mid;
    goto_pc(10, 7);
    stall = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 8'd0) begin failures++; $display("FAIL rmid_addr got=%0d exp=0", imem_addr); end
    tick();
    checks++;
    if (pc !== 8'd0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_state pc=%0d valid=%b exp pc=0 valid=0", pc, instr_valid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (pc !== 8'd0 || instr_valid !== 1'b1) begin
      failures++; $display("FAIL rmid_warm pc=%0d valid=%b exp pc=0 valid=1", pc, instr_valid);
    end
    tick();
    checks++;
    if (pc !== 8'd0) begin failures++; $display("FAIL rmid_stall pc=%0d exp=0", pc); end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 8'd1) begin failures++; $display("FAIL rmid_run pc=%0d exp=1", pc); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = word_at(8'(a));
    test_reset();
    test_inc();
    test_stall();
    test_rel();
    test_imm();
    test_zero_len();
    test_shrink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
